// File: rtl/mem_pkg.sv
// Shared types and helpers for the multi-port byte-enabled memory.
package mem_pkg;

   typedef enum logic {INIT, READY} init_state_t;

   // Number of byte lanes in a word of width w with lane width bw.
   function automatic int unsigned nb_of(input int unsigned w, input int unsigned bw);
      return w / bw;
   endfunction

endpackage

// File: rtl/mem_init_seq.sv
// Clear sequencer: sweeps INIT_VAL through the array after reset or clr,
// and arbitrates the single physical write port between sweep and user.
module mem_init_seq
   import mem_pkg::*;
#(
   parameter int unsigned W                  = 32,
   parameter int unsigned BW                 = 8,
   parameter int unsigned D                  = 128,
   parameter logic [W-1:0] INIT_VAL          = '0,
   localparam int unsigned NB                = nb_of(W, BW),
   localparam int unsigned DW                = $clog2(D)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          we1,
   input  logic [NB-1:0] be1,
   input  logic [DW-1:0] addr1,
   input  logic [W-1:0]  din1,
   output logic          init_busy,
   output logic          wr_en_c,
   output logic [NB-1:0] wr_be_c,
   output logic [DW-1:0] wr_addr_c,
   output logic [W-1:0]  wr_data_c
);

   init_state_t   state, state_nxt;
   logic [DW-1:0] cnt, cnt_nxt;

   // State and sweep counter; reset restarts the sweep from address 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state and write-port mux; user writes are dropped while sweeping.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      wr_en_c   = 1'b0;
      wr_be_c   = '0;
      wr_addr_c = addr1;
      wr_data_c = din1;
      case (state)
         INIT: begin
            wr_en_c   = 1'b1;
            wr_be_c   = '1;
            wr_addr_c = cnt;
            wr_data_c = INIT_VAL;
            if (cnt == DW'(D - 1)) begin
               state_nxt = READY;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + DW'(1);
            end
         end
         READY: begin
            if (we1 && (32'(addr1) < D)) begin
               wr_en_c = 1'b1;
               wr_be_c = be1;
            end
         end
      endcase
      if (clr) begin
         state_nxt = INIT;
         cnt_nxt   = '0;
      end
   end

   assign init_busy = (state == INIT);

endmodule

// File: rtl/mem_mp_bw_init.sv
// Multi-read-port memory with byte-enabled write and built-in clear sweep.
module mem_mp_bw_init
   import mem_pkg::*;
#(
   parameter int unsigned  W        = 32,
   parameter int unsigned  BW       = 8,
   parameter int unsigned  D        = 128,
   parameter int unsigned  NR       = 2,
   parameter int unsigned  REG_RD   = 0,
   parameter logic [W-1:0] INIT_VAL = '0,
   localparam int unsigned DW       = $clog2(D),
   localparam int unsigned NB       = nb_of(W, BW)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   we1,
   input  logic [NB-1:0]          be1,
   input  logic [DW-1:0]          addr1,
   input  logic [W-1:0]           din1,
   input  logic [NR-1:0][DW-1:0]  addr2,
   output logic [NR-1:0][W-1:0]   dout2,
   output logic                   init_busy
);

   logic [W-1:0]  mem [D];

   logic          wr_en_c;
   logic [NB-1:0] wr_be_c;
   logic [DW-1:0] wr_addr_c;
   logic [W-1:0]  wr_data_c;

   mem_init_seq #(
      .W        (W),
      .BW       (BW),
      .D        (D),
      .INIT_VAL (INIT_VAL)
   ) u_seq (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .we1       (we1),
      .be1       (be1),
      .addr1     (addr1),
      .din1      (din1),
      .init_busy (init_busy),
      .wr_en_c   (wr_en_c),
      .wr_be_c   (wr_be_c),
      .wr_addr_c (wr_addr_c),
      .wr_data_c (wr_data_c)
   );

   // Array write, one byte lane at a time; the array has no reset.
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         for (int k = 0; k < int'(NB); k++) begin
            if (wr_be_c[k]) begin
               mem[wr_addr_c][k*BW +: BW] <= wr_data_c[k*BW +: BW];
            end
         end
      end
   end

   for (genvar i = 0; i < int'(NR); i++) begin : g_rd
      logic [DW-1:0] ra;
      logic [W-1:0]  rd_c;

      assign ra   = addr2[i];
      assign rd_c = (32'(ra) < D) ? mem[ra] : '0;

      if (REG_RD != 0) begin : g_reg
         logic [W-1:0] q;

         // Registered read; samples pre-edge contents, so same-edge writes return old data.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               q <= '0;
            end else begin
               q <= init_busy ? '0 : rd_c;
            end
         end

         assign dout2[i] = init_busy ? '0 : q;
      end else begin : g_async
         assign dout2[i] = init_busy ? '0 : rd_c;
      end
   end

endmodule

// File: tb/tb_mem_mp_bw_init.sv
// Bench for mem_mp_bw_init: an async D=128 instance and a registered D=100
// instance share stimulus and are checked against a word-level model.
module tb_mem_mp_bw_init;

   localparam logic [31:0] IV = 32'hA5A5A5A5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              clr = 1'b0;
   logic              we1 = 1'b0;
   logic [3:0]        be1 = '0;
   logic [6:0]        addr1 = '0;
   logic [31:0]       din1 = '0;
   logic [1:0][6:0]   ra = '0;
   logic [1:0][31:0]  dout_a, dout_r;
   logic              busy_a, busy_r;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   always #5 clk = ~clk;

   mem_mp_bw_init #(.W(32), .BW(8), .D(128), .NR(2), .REG_RD(0), .INIT_VAL(IV)) u_a (
      .clk(clk), .rst_n(rst_n), .clr(clr), .we1(we1), .be1(be1), .addr1(addr1),
      .din1(din1), .addr2(ra), .dout2(dout_a), .init_busy(busy_a));

   mem_mp_bw_init #(.W(32), .BW(8), .D(100), .NR(2), .REG_RD(1), .INIT_VAL(IV)) u_r (
      .clk(clk), .rst_n(rst_n), .clr(clr), .we1(we1), .be1(be1), .addr1(addr1),
      .din1(din1), .addr2(ra), .dout2(dout_r), .init_busy(busy_r));

   // ---------------- reference model (index 0: async D=128, 1: registered D=100)
   logic [31:0] mm   [2][128];
   bit          mbusy[2];
   int          mcnt [2];
   logic [31:0] mrq  [2][2];

   function automatic int dep(input int k);
      return (k == 0) ? 128 : 100;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] b);
      logic [31:0] r;
      r = old;
      for (int j = 0; j < 4; j++) if (b[j]) r[8*j +: 8] = d[8*j +: 8];
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            mbusy[k]  <= 1'b1;
            mcnt[k]   <= 0;
            mrq[k][0] <= '0;
            mrq[k][1] <= '0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 2; i++)
               mrq[k][i] <= (mbusy[k] || int'(ra[i]) >= dep(k)) ? 32'h0 : mm[k][ra[i]];
            if (mbusy[k]) mm[k][mcnt[k]] <= IV;
            else if (we1 && int'(addr1) < dep(k))
               mm[k][addr1] <= merge(mm[k][addr1], din1, be1);
            if (clr) begin
               mbusy[k] <= 1'b1;
               mcnt[k]  <= 0;
            end else if (mbusy[k]) begin
               if (mcnt[k] == dep(k) - 1) begin
                  mbusy[k] <= 1'b0;
                  mcnt[k]  <= 0;
               end else begin
                  mcnt[k] <= mcnt[k] + 1;
               end
            end
         end
      end
   end

   function automatic logic [31:0] exp_dout(input int k, input int i);
      if (mbusy[k]) return 32'h0;
      if (k == 0) return mm[0][ra[i]];
      return mrq[1][i];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
      end
   endtask

   // Cycle-by-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (check_en) begin
         chk("busy_a", 32'(busy_a), 32'(mbusy[0]));
         chk("busy_r", 32'(busy_r), 32'(mbusy[1]));
         for (int i = 0; i < 2; i++) begin
            chk("dout_a", dout_a[i], exp_dout(0, i));
            chk("dout_r", dout_r[i], exp_dout(1, i));
         end
      end
   end

   // ---------------- stimulus helpers
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] b);
      addr1 = a; din1 = d; be1 = b; we1 = 1'b1;
      tick();
      we1 = 1'b0;
   endtask

   // Counts edges each instance spends busy; optional clr before edge clr_at+1.
   task automatic sweep_count(input int clr_at, output int n0, output int n1);
      bit b0, b1;
      b0 = busy_a; b1 = busy_r;
      n0 = 0; n1 = 0;
      for (int e = 0; e < 400; e++) begin
         clr = (e == clr_at);
         if (e == 90) we1 = 1'b0;
         @(posedge clk);
         n0 += int'(b0);
         n1 += int'(b1);
         @(negedge clk);
         #1;
         clr = 1'b0;
         b0 = busy_a; b1 = busy_r;
         if (!b0 && !b1) break;
      end
      if (b0 || b1) chk("sweep_timeout", {30'h0, b1, b0}, 32'h0);
   endtask

   task automatic wait_ready();
      for (int n = 0; n < 300 && (busy_a || busy_r); n++) tick();
      chk("ready_timeout", {30'h0, busy_r, busy_a}, 32'h0);
   endtask

   // ---------------- main sequence
   initial begin
      int n0, n1;
      #1 rst_n = 1'b0;
      #10;
      chk("rst_busy_a", 32'(busy_a), 32'h1);
      chk("rst_busy_r", 32'(busy_r), 32'h1);
      chk("rst_dout_r0", dout_r[0], 32'h0);
      chk("rst_dout_r1", dout_r[1], 32'h0);
      check_en = 1'b1;

      // Release with a write held on addr 3 that must be ignored during the sweep.
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      addr1 = 7'd3; din1 = 32'h0; be1 = 4'hF; we1 = 1'b1;
      sweep_count(-1, n0, n1);
      chk("sweep_len_a", 32'(n0), 32'd128);
      chk("sweep_len_r", 32'(n1), 32'd100);

      ra = {7'd3, 7'd3};
      #1;
      chk("blocked_wr_a", dout_a[0], IV);

      // Every address holds INIT_VAL after the sweep.
      for (int a = 0; a < 128; a++) begin
         ra = {7'(a), 7'(a)};
         #1;
         chk("init_a0", dout_a[0], IV);
         chk("init_a1", dout_a[1], IV);
         tick();
         chk("init_r0", dout_r[0], (a < 100) ? IV : 32'h0);
      end

      // Byte-lane merge.
      wr(7'd5, 32'h11223344, 4'b1111);
      wr(7'd5, 32'hFFFFFFFF, 4'b0101);
      ra = {7'd5, 7'd5};
      tick();
      chk("be_a", dout_a[0], 32'h11FF33FF);
      chk("be_r", dout_r[1], 32'h11FF33FF);

      // Same-edge write and read of addr 7.
      ra = {7'd7, 7'd7};
      tick();
      wr(7'd7, 32'hDEADBEEF, 4'hF);
      chk("rbw_a_same", dout_a[0], 32'hDEADBEEF);
      chk("rbw_r_old", dout_r[0], IV);
      tick();
      chk("rbw_r_new", dout_r[0], 32'hDEADBEEF);

      // Out-of-range address on the D=100 instance; be1=0 is a no-op.
      wr(7'd110, 32'h12345678, 4'hF);
      wr(7'd110, 32'hFFFFFFFF, 4'h0);
      ra = {7'd110, 7'd110};
      tick();
      chk("oor_a", dout_a[0], 32'h12345678);
      chk("oor_r", dout_r[0], 32'h0);

      // Randomized traffic with occasional clr.
      for (int c = 0; c < 1500; c++) begin
         we1   = 1'($urandom_range(0, 1));
         be1   = 4'($urandom);
         addr1 = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 7)) : 7'($urandom);
         din1  = $urandom;
         for (int i = 0; i < 2; i++)
            ra[i] = ($urandom_range(0, 2) == 0) ? addr1 : 7'($urandom);
         clr   = ($urandom_range(0, 299) == 0);
         tick();
         clr = 1'b0;
      end
      we1 = 1'b0;
      wait_ready();

      // Asynchronous reset in READY, then a mid-sweep clr.
      ra = {7'd5, 7'd5};
      wr(7'd5, 32'h11FF33FF, 4'hF);
      tick();
      chk("pre_rst_r", dout_r[0], 32'h11FF33FF);
      rst_n = 1'b0;
      #1;
      chk("arst_busy_a", 32'(busy_a), 32'h1);
      chk("arst_busy_r", 32'(busy_r), 32'h1);
      chk("arst_dout_r", dout_r[0], 32'h0);
      chk("arst_dout_a", dout_a[0], 32'h0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      sweep_count(60, n0, n1);
      chk("clr_len_a", 32'(n0), 32'd189);
      chk("clr_len_r", 32'(n1), 32'd161);
      tick();
      chk("post_clr_a", dout_a[0], IV);
      chk("post_clr_r", dout_r[0], IV);

      repeat (3) tick();
      check_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
